// File: rtl/sec_display_driver.sv
// Seconds display driver: resynchronises a 6-bit count, converts it to two
// BCD digits with a repeated-subtract FSM, and scans a two-digit
// common-anode 7-segment display with optional leading-zero blanking.
module sec_display_driver #(
    parameter int unsigned SCAN_DIV = 50000,
    parameter int unsigned DEAD_CYC = 2
) (
    input  logic       CLOCK,
    input  logic       NRESET,
    input  logic [5:0] VALUE,
    input  logic       BLANK_LZ,
    output logic [6:0] SEG,
    output logic [1:0] DIG,
    output logic [3:0] BCD_TENS,
    output logic [3:0] BCD_ONES,
    output logic       UPD
);

    localparam int unsigned SCAN_N = (SCAN_DIV < 4) ? 4 : SCAN_DIV;
    localparam int unsigned CNT_W  = $clog2(SCAN_N);
    localparam int unsigned VAL_W  = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SUB  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Active-low gfedcba glyph; non-decimal codes show nothing
    function automatic logic [6:0] glyph(input logic [3:0] d);
        logic [6:0] g;
        case (d)
            4'd0:    g = 7'h40;
            4'd1:    g = 7'h79;
            4'd2:    g = 7'h24;
            4'd3:    g = 7'h30;
            4'd4:    g = 7'h19;
            4'd5:    g = 7'h12;
            4'd6:    g = 7'h02;
            4'd7:    g = 7'h78;
            4'd8:    g = 7'h00;
            4'd9:    g = 7'h10;
            default: g = 7'h7F;
        endcase
        return g;
    endfunction

    logic [VAL_W-1:0] s1_q, s2_q, s3_q;
    state_e           state_q, state_d;
    logic [VAL_W-1:0] held_q, held_d;
    logic [VAL_W-1:0] rem_q, rem_d;
    logic [2:0]       tens_q, tens_d;
    logic [3:0]       bcd_tens_q, bcd_tens_d;
    logic [3:0]       bcd_ones_q, bcd_ones_d;
    logic             upd_q, upd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sel_q, sel_d;
    logic [1:0]       dig_q, dig_d;
    logic [6:0]       seg_q, seg_d;
    logic             stable_c;
    logic             term_c;

    assign stable_c = (s2_q == s3_q);
    assign term_c   = (cnt_q == CNT_W'(SCAN_N - 1));

    // Two-flop synchroniser plus compare stage for stability detection
    always_ff @(posedge CLOCK or negedge NRESET) begin
        if (!NRESET) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            s1_q <= VALUE;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    // Conversion FSM and datapath registers
    always_ff @(posedge CLOCK or negedge NRESET) begin
        if (!NRESET) begin
            state_q    <= ST_IDLE;
            held_q     <= '0;
            rem_q      <= '0;
            tens_q     <= '0;
            bcd_tens_q <= '0;
            bcd_ones_q <= '0;
            upd_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            held_q     <= held_d;
            rem_q      <= rem_d;
            tens_q     <= tens_d;
            bcd_tens_q <= bcd_tens_d;
            bcd_ones_q <= bcd_ones_d;
            upd_q      <= upd_d;
        end
    end

    // Next-state: capture a new stable sample, subtract tens, publish result
    always_comb begin
        state_d    = state_q;
        held_d     = held_q;
        rem_d      = rem_q;
        tens_d     = tens_q;
        bcd_tens_d = bcd_tens_q;
        bcd_ones_d = bcd_ones_q;
        upd_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (stable_c && (s2_q != held_q)) begin
                    held_d  = s2_q;
                    rem_d   = s2_q;
                    tens_d  = '0;
                    state_d = ST_SUB;
                end
            end
            ST_SUB: begin
                if (rem_q >= VAL_W'(10)) begin
                    rem_d  = VAL_W'(rem_q - VAL_W'(10));
                    tens_d = 3'(tens_q + 3'd1);
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                bcd_tens_d = {1'b0, tens_q};
                bcd_ones_d = rem_q[3:0];
                upd_d      = 1'b1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Scan counter, digit select and registered display drive
    always_ff @(posedge CLOCK or negedge NRESET) begin
        if (!NRESET) begin
            cnt_q <= '0;
            sel_q <= 1'b0;
            dig_q <= 2'b11;
            seg_q <= 7'h7F;
        end else begin
            cnt_q <= cnt_d;
            sel_q <= sel_d;
            dig_q <= dig_d;
            seg_q <= seg_d;
        end
    end

    // Free-running scan; dead time and blanked tens slot drive everything off
    always_comb begin
        cnt_d = term_c ? '0 : CNT_W'(cnt_q + CNT_W'(1));
        sel_d = term_c ? ~sel_q : sel_q;
        dig_d = 2'b11;
        seg_d = 7'h7F;
        if (cnt_q >= CNT_W'(DEAD_CYC)) begin
            if (!sel_q) begin
                dig_d = 2'b10;
                seg_d = glyph(bcd_ones_q);
            end else if (!(BLANK_LZ && (bcd_tens_q == 4'd0))) begin
                dig_d = 2'b01;
                seg_d = glyph(bcd_tens_q);
            end
        end
    end

    assign SEG      = seg_q;
    assign DIG      = dig_q;
    assign BCD_TENS = bcd_tens_q;
    assign BCD_ONES = bcd_ones_q;
    assign UPD      = upd_q;

endmodule

// File: tb/tb_sec_display_driver.sv
// Self-checking bench for sec_display_driver: directed and random values,
// checked against a decimal/phase reference model.
module tb_sec_display_driver;

    localparam int unsigned SCAN = 8;
    localparam int unsigned DEAD = 2;

    logic       CLOCK;
    logic       NRESET;
    logic [5:0] VALUE;
    logic       BLANK_LZ;
    logic [6:0] SEG;
    logic [1:0] DIG;
    logic [3:0] BCD_TENS;
    logic [3:0] BCD_ONES;
    logic       UPD;

    int n_tests = 0;
    int n_fail  = 0;
    int t_edge;
    int exp_tens;
    int exp_ones;
    logic [6:0] glyph_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                   7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    sec_display_driver #(.SCAN_DIV(SCAN), .DEAD_CYC(DEAD)) dut (
        .CLOCK    (CLOCK),
        .NRESET   (NRESET),
        .VALUE    (VALUE),
        .BLANK_LZ (BLANK_LZ),
        .SEG      (SEG),
        .DIG      (DIG),
        .BCD_TENS (BCD_TENS),
        .BCD_ONES (BCD_ONES),
        .UPD      (UPD)
    );

    initial begin
        CLOCK = 1'b0;
        forever #5 CLOCK = ~CLOCK;
    end

    // Clock edges seen since reset release: gives the scan phase
    always @(posedge CLOCK or negedge NRESET) begin
        if (!NRESET) t_edge <= 0;
        else         t_edge <= t_edge + 1;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLOCK);
        #1;
    endtask

    // Display model: slot of SCAN cycles, first DEAD cycles dark, ones slot first
    task automatic check_scan(input int n);
        int ph, slot;
        logic [1:0] edig;
        logic [6:0] eseg;
        for (int i = 0; i < n; i++) begin
            step();
            ph   = (t_edge - 1) % SCAN;
            slot = ((t_edge - 1) / SCAN) % 2;
            if (ph < DEAD) begin
                edig = 2'b11; eseg = 7'h7F;
            end else if (slot == 0) begin
                edig = 2'b10; eseg = glyph_tab[exp_ones];
            end else if (BLANK_LZ && exp_tens == 0) begin
                edig = 2'b11; eseg = 7'h7F;
            end else begin
                edig = 2'b01; eseg = glyph_tab[exp_tens];
            end
            check("scan_dig", 16'(DIG), 16'(edig));
            check("scan_seg", 16'(SEG), 16'(eseg));
            check("scan_upd_idle", 16'(UPD), 16'd0);
            check("scan_bcd_tens", 16'(BCD_TENS), 16'(exp_tens));
            check("scan_bcd_ones", 16'(BCD_ONES), 16'(exp_ones));
        end
    endtask

    // Wait (bounded) for UPD, check its latency and the published digits
    task automatic wait_upd(input int exp_lat, input string tag);
        int  lat;
        bit  seen;
        seen = 1'b0;
        lat  = 0;
        for (int k = 1; k <= 40 && !seen; k++) begin
            step();
            if (UPD === 1'b1) begin
                seen = 1'b1;
                lat  = k;
            end
        end
        check({tag, "_upd_seen"}, 16'(seen), 16'd1);
        if (seen) begin
            check({tag, "_latency"}, 16'(lat), 16'(exp_lat));
            check({tag, "_tens"}, 16'(BCD_TENS), 16'(exp_tens));
            check({tag, "_ones"}, 16'(BCD_ONES), 16'(exp_ones));
        end
    endtask

    // Drive a new value and expect one conversion: 3 sync + 1 capture + tens+1 SUB + 1 DONE
    task automatic convert(input int v, input string tag);
        VALUE    = 6'(v);
        exp_tens = v / 10;
        exp_ones = v % 10;
        wait_upd(exp_tens + 6, tag);
    endtask

    initial begin
        int cur;
        int v;
        NRESET   = 1'b0;
        VALUE    = 6'd0;
        BLANK_LZ = 1'b0;
        exp_tens = 0;
        exp_ones = 0;
        repeat (3) @(posedge CLOCK);
        #1;
        check("rst_seg", 16'(SEG), 16'h7F);
        check("rst_dig", 16'(DIG), 16'h3);
        check("rst_tens", 16'(BCD_TENS), 16'd0);
        check("rst_ones", 16'(BCD_ONES), 16'd0);
        check("rst_upd", 16'(UPD), 16'd0);
        @(negedge CLOCK);
        NRESET = 1'b1;

        // Idle display after reset: "00", no update pulse
        check_scan(20);

        // 0 -> 59
        convert(59, "v59");
        check_scan(16);

        // Leading-zero blanking on, then off
        BLANK_LZ = 1'b1;
        convert(7, "v7");
        check_scan(16);
        BLANK_LZ = 1'b0;
        check_scan(16);

        // Burst while converting: 58 captured, 59 too brief, 0 picked up afterwards
        VALUE    = 6'd58;
        exp_tens = 5;
        exp_ones = 8;
        for (int i = 0; i < 5; i++) begin
            step();
            check("burst_no_upd", 16'(UPD), 16'd0);
        end
        VALUE = 6'd59;
        step();
        check("burst_no_upd", 16'(UPD), 16'd0);
        VALUE = 6'd0;
        wait_upd(5, "burst58");
        exp_tens = 0;
        exp_ones = 0;
        wait_upd(3, "burst0");
        check_scan(16);

        // Reset during conversion of 45 aborts it; rerun after release
        VALUE = 6'd45;
        repeat (6) step();
        NRESET = 1'b0;
        #1;
        check("arst_seg", 16'(SEG), 16'h7F);
        check("arst_dig", 16'(DIG), 16'h3);
        check("arst_tens", 16'(BCD_TENS), 16'd0);
        check("arst_ones", 16'(BCD_ONES), 16'd0);
        check("arst_upd", 16'(UPD), 16'd0);
        @(posedge CLOCK);
        @(negedge CLOCK);
        NRESET   = 1'b1;
        exp_tens = 4;
        exp_ones = 5;
        wait_upd(10, "v45_rerun");
        check_scan(16);

        // Largest input
        convert(63, "v63");
        check_scan(16);
        cur = 63;

        // Random values and blanking
        for (int r = 0; r < 12; r++) begin
            v = int'($urandom_range(63));
            if (v == cur) v = (v + 1) % 64;
            BLANK_LZ = 1'($urandom_range(1));
            convert(v, "rand");
            check_scan(20);
            cur = v;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
